// File: rtl/fp_div_operand_prep.sv
// FP32 divider operand-prep stage: classifies A/B pairs, resolves IEEE-754 special
// quotients and queues results in a DEPTH-entry FIFO. Optional DAZ via FP_PREP_DAZ_EN.
module fp_div_operand_prep #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_a,
  output logic [31:0]              out_b,
  output logic [31:0]              out_special,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Operand field decode
  logic        a_denorm_raw;
  logic        b_denorm_raw;
  logic [31:0] a_eff;
  logic [31:0] b_eff;

  assign a_denorm_raw = (in_a[30:23] == 8'd0) && (in_a[22:0] != 23'd0);
  assign b_denorm_raw = (in_b[30:23] == 8'd0) && (in_b[22:0] != 23'd0);

`ifdef FP_PREP_DAZ_EN
  assign a_eff = a_denorm_raw ? {in_a[31], 31'd0} : in_a;
  assign b_eff = b_denorm_raw ? {in_b[31], 31'd0} : in_b;
`else
  assign a_eff = in_a;
  assign b_eff = in_b;
`endif

  logic a_zero;
  logic a_inf;
  logic a_nan;
  logic b_zero;
  logic b_inf;
  logic b_nan;
  logic sign_q;

  assign a_zero = (a_eff[30:0] == 31'd0);
  assign a_inf  = (a_eff[30:23] == 8'hFF) && (a_eff[22:0] == 23'd0);
  assign a_nan  = (a_eff[30:23] == 8'hFF) && (a_eff[22:0] != 23'd0);
  assign b_zero = (b_eff[30:0] == 31'd0);
  assign b_inf  = (b_eff[30:23] == 8'hFF) && (b_eff[22:0] == 23'd0);
  assign b_nan  = (b_eff[30:23] == 8'hFF) && (b_eff[22:0] != 23'd0);
  assign sign_q = in_a[31] ^ in_b[31];

  // Special-case resolution, first match wins
  logic [31:0] cls_special;
  logic        cls_invalid;
  logic        cls_dbz;
  logic        cls_bypass;
  logic        cls_denorm;

  always_comb begin
    cls_special = '0;
    cls_invalid = 1'b0;
    cls_dbz     = 1'b0;
    cls_bypass  = 1'b0;
    cls_denorm  = a_denorm_raw | b_denorm_raw;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      cls_special = QNAN;
      cls_invalid = 1'b1;
      cls_bypass  = 1'b1;
    end else if (a_inf) begin
      cls_special = {sign_q, 8'hFF, 23'd0};
      cls_bypass  = 1'b1;
    end else if (b_zero) begin
      cls_special = {sign_q, 8'hFF, 23'd0};
      cls_dbz     = 1'b1;
      cls_bypass  = 1'b1;
    end else if (a_zero || b_inf) begin
      cls_special = {sign_q, 31'd0};
      cls_bypass  = 1'b1;
    end
  end

  // FIFO storage and control
  logic [31:0]   mem_a       [DEPTH];
  logic [31:0]   mem_b       [DEPTH];
  logic [31:0]   mem_special [DEPTH];
  logic [3:0]    mem_flags   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign in_ready  = !rst && (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_a       = mem_a[rd_ptr];
  assign out_b       = mem_b[rd_ptr];
  assign out_special = mem_special[rd_ptr];
  assign out_flags   = mem_flags[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_a[i]       <= '0;
        mem_b[i]       <= '0;
        mem_special[i] <= '0;
        mem_flags[i]   <= '0;
      end
    end else if (push) begin
      mem_a[wr_ptr]       <= a_eff;
      mem_b[wr_ptr]       <= b_eff;
      mem_special[wr_ptr] <= cls_special;
      mem_flags[wr_ptr]   <= {cls_invalid, cls_dbz, cls_denorm, cls_bypass};
    end
  end

  // Pointers are PW bits wide; DEPTH is a power of two so +1 wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

endmodule
